// File: rtl/page_tbl_access_arbiter.sv
// page_tbl_access_arbiter: zero-fills, then shares the VLAN page-table port between round-robin lookups and priority config writes
// Ports: clk/rst_n; req_vlan_in/req_valid_in/req_ready_out lookup handshake; rsp_data_out/rsp_valid_out tagged responses;
// cfg_wr_addr/cfg_wr_data/cfg_wr_valid/cfg_wr_ready config write; ram_addr/ram_wr_en/ram_wr_data/ram_rd_data RAM port; init_done_out.
module page_tbl_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int C_VLANID_WIDTH = 12,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 16,
  parameter int STARVE_LIMIT   = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ*C_VLANID_WIDTH-1:0] req_vlan_in,
  input  logic [NUM_REQ-1:0]                req_valid_in,
  output logic [NUM_REQ-1:0]                req_ready_out,
  output logic [DATA_W-1:0]                 rsp_data_out,
  output logic [NUM_REQ-1:0]                rsp_valid_out,
  input  logic [ADDR_W-1:0]                 cfg_wr_addr,
  input  logic [DATA_W-1:0]                 cfg_wr_data,
  input  logic                              cfg_wr_valid,
  output logic                              cfg_wr_ready,
  output logic [ADDR_W-1:0]                 ram_addr,
  output logic                              ram_wr_en,
  output logic [DATA_W-1:0]                 ram_wr_data,
  input  logic [DATA_W-1:0]                 ram_rd_data,
  output logic                              init_done_out
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] init_cnt;
  logic [PW-1:0] rr_ptr, sel;
  logic [SW-1:0] wr_streak;
  logic [NUM_REQ-1:0] tag1, tag2, gnt;
  logic run, rd_elig, grant_wr, grant_rd;
  // Descending search so the last hit is the requester nearest rr_ptr+1.
  always_comb begin
    run = state == RUN;
    rd_elig = |req_valid_in;
    grant_wr = run && cfg_wr_valid && !(rd_elig && wr_streak == SW'(STARVE_LIMIT));
    grant_rd = run && rd_elig && !grant_wr;
    sel = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req_valid_in[(int'(rr_ptr) + k) % NUM_REQ]) sel = PW'((int'(rr_ptr) + k) % NUM_REQ);
    gnt = grant_rd ? NUM_REQ'(1) << sel : '0;
    state_nx = (state == INIT && init_cnt == '1) ? RUN : state;
  end
  assign req_ready_out = gnt;
  assign cfg_wr_ready  = grant_wr;
  assign init_done_out = run;
  // tag1 rides with ram_addr, tag2 with ram_rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= '0;
      rr_ptr        <= PW'(NUM_REQ - 1);
      wr_streak     <= '0;
      tag1          <= '0;
      tag2          <= '0;
      rsp_valid_out <= '0;
      rsp_data_out  <= '0;
      ram_addr      <= '0;
      ram_wr_en     <= 1'b0;
      ram_wr_data   <= '0;
    end else begin
      state         <= state_nx;
      tag1          <= gnt;
      tag2          <= tag1;
      rsp_valid_out <= tag2;
      if (|tag2) rsp_data_out <= ram_rd_data;
      if (!run) begin
        init_cnt    <= init_cnt + 1'b1;
        ram_addr    <= init_cnt;
        ram_wr_en   <= 1'b1;
        ram_wr_data <= '0;
        wr_streak   <= '0;
      end else begin
        ram_wr_en <= grant_wr;
        if (grant_wr) begin
          ram_addr    <= cfg_wr_addr;
          ram_wr_data <= cfg_wr_data;
        end else if (grant_rd) begin
          ram_addr <= req_vlan_in[int'(sel)*C_VLANID_WIDTH + 4 +: ADDR_W];
          rr_ptr   <= sel;
        end
        wr_streak <= (grant_rd || !rd_elig) ? '0 : grant_wr ? wr_streak + 1'b1 : wr_streak;
      end
    end
  end
endmodule

// File: tb/tb_page_tbl_access_arbiter.sv
// tb_page_tbl_access_arbiter: directed checks of init sweep, read path, round-robin, starvation guard, RAW and mid-flight reset
module tb_page_tbl_access_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [47:0] req_vlan;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [15:0] rsp_data, cfg_wr_data, ram_wr_data, ram_rd_data;
  logic [4:0] cfg_wr_addr, ram_addr;
  logic cfg_wr_valid, cfg_wr_ready, ram_wr_en, init_done;
  logic [15:0] mem [32];
  int n_chk = 0;
  int n_pass = 0;
  int rr_exp [8] = '{3, 0, 1, 2, 3, 0, 1, 2};
  int bad;
  logic rd;
  page_tbl_access_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_vlan_in(req_vlan), .req_valid_in(req_valid),
    .req_ready_out(req_ready), .rsp_data_out(rsp_data), .rsp_valid_out(rsp_valid),
    .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data), .cfg_wr_valid(cfg_wr_valid),
    .cfg_wr_ready(cfg_wr_ready), .ram_addr(ram_addr), .ram_wr_en(ram_wr_en),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .init_done_out(init_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_addr];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic check_reset_values();
    chk("rst_ready", {27'd0, req_ready, cfg_wr_ready}, 0);
    chk("rst_rsp", {rsp_valid, rsp_data}, 0);
    chk("rst_ram", {ram_addr, ram_wr_en, ram_wr_data}, 0);
    chk("rst_init_done", init_done, 0);
  endtask
  task automatic sweep();
    int bad_addr = 0, bad_wr = 0, bad_rdy = 0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (ram_addr !== c[4:0]) bad_addr++;
      if (ram_wr_en !== 1'b1 || ram_wr_data !== 16'h0) bad_wr++;
      if (c < 31 && (req_ready !== 4'h0 || cfg_wr_ready !== 1'b0)) bad_rdy++;
      if (c == 30) begin
        chk("init_not_done", init_done, 0);
        req_valid = 4'h0;
        cfg_wr_valid = 1'b0;
      end
    end
    chk("init_done", init_done, 1);
    chk("init_addr_seq", bad_addr, 0);
    chk("init_wr_zero", bad_wr, 0);
    chk("init_no_ready", bad_rdy, 0);
  endtask
  initial begin
    req_vlan = '0;
    req_valid = '0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cfg_wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    req_valid = 4'hF;
    cfg_wr_valid = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    cfg_wr_addr = 5'd10;
    cfg_wr_data = 16'h1234;
    cfg_wr_valid = 1'b1;
    #1 chk("wr_ready", cfg_wr_ready, 1);
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    chk("wr_ram", {ram_wr_en, ram_addr, ram_wr_data}, {1'b1, 5'd10, 16'h1234});
    req_vlan[24 +: 12] = 12'h0A5;
    req_valid = 4'b0100;
    #1 chk("rd_ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = 4'h0;
    chk("rd_ram", {ram_wr_en, ram_addr}, {1'b0, 5'h0A});
    @(negedge clk);
    chk("rd_early", rsp_valid, 0);
    @(negedge clk);
    chk("rd_rsp", {rsp_valid, rsp_data}, {4'b0100, 16'h1234});
    @(negedge clk);
    req_vlan = {12'h070, 12'h0A0, 12'h050, 12'h040};
    for (int k = 0; k < 11; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) chk("rr_grant", req_ready, 1 << rr_exp[k]);
      if (k >= 3) begin
        chk("rr_tag", rsp_valid, 1 << rr_exp[k-3]);
        chk("rr_data", rsp_data, (rr_exp[k-3] == 2) ? 16'h1234 : 16'h0);
      end else chk("rr_idle", rsp_valid, 0);
      @(negedge clk);
    end
    cfg_wr_addr = 5'd20;
    cfg_wr_valid = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 18; k++) begin
      cfg_wr_data = 16'(k);
      rd = (k % 9 == 8);
      #1;
      chk("sv_wr", cfg_wr_ready, rd ? 0 : 1);
      chk("sv_rd", req_ready, rd ? 4'b0010 : 4'b0000);
      @(negedge clk);
    end
    cfg_wr_valid = 1'b0;
    req_valid = 4'h0;
    repeat (4) @(negedge clk);
    cfg_wr_addr = 5'd3;
    cfg_wr_data = 16'hBEEF;
    cfg_wr_valid = 1'b1;
    #1 chk("raw_wr", cfg_wr_ready, 1);
    @(negedge clk);
    cfg_wr_valid = 1'b0;
    req_vlan[11:0] = 12'h030;
    req_valid = 4'b0001;
    #1 chk("raw_rd", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    chk("raw_early", rsp_valid, 0);
    @(negedge clk);
    chk("raw_rsp", {rsp_valid, rsp_data}, {4'b0001, 16'hBEEF});
    @(negedge clk);
    req_valid = 4'b0011;
    #1 chk("mf_g1", req_ready, 4'b0010);
    @(negedge clk);
    #1 chk("mf_g2", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = 4'h0;
    rst_n = 1'b0;
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (rsp_valid !== 4'h0) bad++;
      @(negedge clk);
    end
    chk("mf_no_rsp", bad, 0);
    req_valid = 4'hF;
    cfg_wr_valid = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    sweep();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
